// File: rtl/prng_pkg.sv
// Shared constants and FSM state type for the PRNG LFSR block.
package prng_pkg;

  localparam int MODE_GALOIS    = 0;
  localparam int MODE_FIBONACCI = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2
  } fsm_t;

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-step LFSR next-state function, Galois or Fibonacci.
module lfsr_step
  import prng_pkg::*;
#(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = 6'b100110,
  parameter int               MODE  = MODE_GALOIS
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  generate
    if (MODE == MODE_FIBONACCI) begin : g_fib
      assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
    end else begin : g_galois
      // The feedback bit re-enters at bit 0, so TAPS[0] plays no part.
      assign nxt = {cur[WIDTH-2:0] ^ ({(WIDTH-1){cur[WIDTH-1]}} & TAPS[WIDTH-1:1]),
                    cur[WIDTH-1]};
    end
  endgenerate

endmodule

// File: rtl/prng_lfsr.sv
// LFSR pseudo-random word source with valid/ready output, seed load and zero-seed recovery.
// Optional period detector enabled by defining PRNG_LFSR_PERIOD_EN.
module prng_lfsr
  import prng_pkg::*;
#(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] TAPS  = 6'b100110,
  parameter logic [WIDTH-1:0] SEED  = 6'b101101,
  parameter int               MODE  = MODE_GALOIS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             lockup
`ifdef PRNG_LFSR_PERIOD_EN
  ,
  output logic             period_done,
  output logic [WIDTH-1:0] period_count
`endif
);

  fsm_t             fsm, fsm_nxt;
  logic [WIDTH-1:0] state, state_nxt, step;
  logic             lockup_nxt;
  logic             adv;      // state advances by one LFSR step
  logic             clr;      // period counting restarts
  logic             reseed;   // state replaced by a new reference value
  logic             load_acc;

  lfsr_step #(.WIDTH(WIDTH), .TAPS(TAPS), .MODE(MODE)) u_step (
    .cur (state),
    .nxt (step)
  );

  assign load_acc  = load && (fsm != RECOVER);
  assign out_valid = (fsm == RUN);
  assign out_data  = state;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    fsm_nxt    = fsm;
    state_nxt  = state;
    lockup_nxt = 1'b0;
    adv        = 1'b0;
    clr        = 1'b0;
    reseed     = 1'b0;
    unique case (fsm)
      IDLE: if (en) fsm_nxt = RUN;
      RUN: begin
        if (out_ready) begin
          state_nxt = step;
          adv       = 1'b1;
        end
        if (!en) fsm_nxt = IDLE;
      end
      RECOVER: begin
        state_nxt  = SEED;
        lockup_nxt = 1'b1;
        clr        = 1'b1;
        reseed     = 1'b1;
        fsm_nxt    = en ? RUN : IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
    // A zero seed is never written; the held state is replaced by SEED one cycle later.
    if (load_acc) begin
      adv = 1'b0;
      clr = 1'b1;
      if (seed_in != '0) begin
        state_nxt = seed_in;
        reseed    = 1'b1;
        fsm_nxt   = en ? RUN : IDLE;
      end else begin
        state_nxt = state;
        reseed    = 1'b0;
        fsm_nxt   = RECOVER;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm    <= IDLE;
      state  <= SEED;
      lockup <= 1'b0;
    end else begin
      fsm    <= fsm_nxt;
      state  <= state_nxt;
      lockup <= lockup_nxt;
    end
  end

`ifdef PRNG_LFSR_PERIOD_EN
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period_ref;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      period_ref   <= SEED;
      period_done  <= 1'b0;
      period_count <= '0;
    end else begin
      period_done <= 1'b0;
      if (clr) begin
        cnt <= '0;
        if (reseed) period_ref <= state_nxt;
      end else if (adv) begin
        if (step == period_ref) begin
          period_done  <= 1'b1;
          period_count <= cnt + WIDTH'(1);
          cnt          <= '0;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end
    end
  end
`else
  logic unused_period;
  assign unused_period = ^{adv, clr, reseed};
`endif

endmodule

// File: tb/tb_prng_lfsr.sv
// Directed self-checking bench for prng_lfsr: default 6-bit Galois instance plus a 4-bit period instance.
module tb_prng_lfsr;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, load, out_ready;
  logic [5:0] seed_in;
  logic       out_valid, lockup;
  logic [5:0] out_data;

  logic       en4, load4, ready4;
  logic [3:0] seed4;
  logic       valid4, lockup4;
  logic [3:0] data4;

`ifdef PRNG_LFSR_PERIOD_EN
  logic       done6, done4;
  logic [5:0] cnt6;
  logic [3:0] cnt4;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ret_step;

  always #5 clk = ~clk;

  prng_lfsr dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .load         (load),
    .seed_in      (seed_in),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .lockup       (lockup)
`ifdef PRNG_LFSR_PERIOD_EN
    ,
    .period_done  (done6),
    .period_count (cnt6)
`endif
  );

  prng_lfsr #(.WIDTH(4), .TAPS(4'b0010), .SEED(4'b1001), .MODE(0)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .en           (en4),
    .load         (load4),
    .seed_in      (seed4),
    .out_ready    (ready4),
    .out_valid    (valid4),
    .out_data     (data4),
    .lockup       (lockup4)
`ifdef PRNG_LFSR_PERIOD_EN
    ,
    .period_done  (done4),
    .period_count (cnt4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; out_ready = 1'b0; seed_in = '0;
    en4 = 1'b0; load4 = 1'b0; ready4 = 1'b0; seed4 = '0;
    tick();
    check("rst_data", out_data, 6'b101101);
    check("rst_valid", out_valid, 0);
    check("rst_lockup", lockup, 0);
    reset = 1'b0;

    // IDLE -> RUN, then first advance.
    en = 1'b1; out_ready = 1'b1;
    tick();
    check("run_valid", out_valid, 1);
    check("run_data0", out_data, 6'b101101);
    tick();
    check("adv1", out_data, 6'b111101);

    // Back-pressure holds the word.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_data", out_data, 6'b111101);
      check("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    check("adv2", out_data, 6'b011101);

    // Load overrides a same-cycle handshake.
    load = 1'b1; seed_in = 6'b000001;
    tick();
    check("load_data", out_data, 6'b000001);
    load = 1'b0; out_ready = 1'b0;
    tick();
    check("load_hold", out_data, 6'b000001);
    out_ready = 1'b1;
    tick();
    check("adv_from_1", out_data, 6'b000010);

    // Zero seed goes through RECOVER.
    load = 1'b1; seed_in = 6'b000000;
    tick();
    check("rec_valid", out_valid, 0);
    check("rec_lockup", lockup, 0);
    check("rec_data", out_data, 6'b000010);
    load = 1'b0;
    tick();
    check("rec_seed", out_data, 6'b101101);
    check("rec_pulse", lockup, 1);
    check("rec_valid1", out_valid, 1);
    tick();
    check("rec_pulse_end", lockup, 0);
    check("rec_adv", out_data, 6'b111101);

    // Load during RECOVER is ignored.
    load = 1'b1; seed_in = 6'b000000;
    tick();
    check("rec2_valid", out_valid, 0);
    seed_in = 6'b000001;
    tick();
    check("rec2_ignore", out_data, 6'b101101);
    check("rec2_pulse", lockup, 1);
    load = 1'b0;

    // en drop with handshake: advance still happens, then IDLE.
    en = 1'b0; out_ready = 1'b1;
    tick();
    check("endrop_adv", out_data, 6'b111101);
    check("endrop_valid", out_valid, 0);
    tick();
    check("idle_hold", out_data, 6'b111101);

    // Reset in the middle of RECOVER.
    en = 1'b1; out_ready = 1'b0;
    tick();
    check("pre_rec_valid", out_valid, 1);
    load = 1'b1; seed_in = 6'b000000;
    tick();
    check("pre_rst_valid", out_valid, 0);
    load = 1'b0;
    reset = 1'b1;
    #1;
    check("arst_data", out_data, 6'b101101);
    check("arst_valid", out_valid, 0);
    check("arst_lockup", lockup, 0);
    en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_lockup", lockup, 0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_data", out_data, 6'b101101);

    // 4-bit maximal-length instance: state returns to the seed after 15 advances.
    en4 = 1'b1; ready4 = 1'b1;
    tick();
    check("w4_start", data4, 4'b1001);
    ret_step = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("w4_nonzero", data4 != 4'b0000, 1);
`ifdef PRNG_LFSR_PERIOD_EN
      if (data4 != 4'b1001) check("w4_no_done", done4, 0);
`endif
      if (data4 == 4'b1001) begin
        ret_step = i;
`ifdef PRNG_LFSR_PERIOD_EN
        check("w4_done", done4, 1);
        check("w4_count", cnt4, 15);
`endif
        break;
      end
    end
    check("w4_period", ret_step, 15);
`ifdef PRNG_LFSR_PERIOD_EN
    tick();
    check("w4_done_pulse", done4, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prng_lfsr.md
PRNG_LFSR -- requirements
Module: prng_lfsr

Interface
REQ-001 Parameter WIDTH, default 6: LFSR state width; legal range 3..32.
REQ-002 Parameter TAPS, default 6'b100110: tap mask [WIDTH-1:0]; bit 0 ignored in Galois mode.
REQ-003 Parameter SEED, default 6'b101101: reset and recovery state; must be nonzero.
REQ-004 Parameter MODE, default 0: 0 = Galois, 1 = Fibonacci.
REQ-005 clk  input  1  clock; all state changes occur on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 en  input  1  level; run enable.
REQ-008 load  input  1  single-cycle seed load strobe.
REQ-009 seed_in  input  WIDTH  value loaded on load.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_valid  output  1  out_data holds a valid word.
REQ-012 out_data  output  WIDTH  current LFSR state.
REQ-013 lockup  output  1  one-cycle pulse when a zero seed is replaced by SEED.

Function
REQ-014 FSM SHALL have three states: IDLE, RUN and RECOVER.
REQ-015 Galois step SHALL be: next[0] = cur[W-1]; for i > 0, next[i] = cur[i-1] ^ (TAPS[i] & cur[W-1]).
REQ-016 Fibonacci step SHALL be: next = {cur[W-2:0], ^(cur & TAPS)}.
REQ-017 IDLE: out_valid = 0; en = 1 -> RUN the next cycle; state held.
REQ-018 RUN: out_valid = 1; state SHALL advance one step only on a cycle with out_valid & out_ready.
REQ-019 RUN with en = 0 -> IDLE the next cycle; a handshake in that same cycle still advances the state.
REQ-020 out_data SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-021 load (any state), seed_in nonzero: state <= seed_in; FSM <= RUN if en else IDLE; load overrides a same-cycle handshake.
REQ-022 load with seed_in == 0: FSM <= RECOVER, out_valid = 0 for one cycle; then state <= SEED, lockup = 1 for that cycle, FSM <= RUN if en else IDLE.
REQ-023 The state register SHALL never hold all-zeros.
REQ-024 load during RECOVER SHALL be ignored.
REQ-025 Latency SHALL be: handshake -> new out_data on the next cycle; load -> seed_in visible on out_data the next cycle.

Reset
REQ-026 Reset SHALL force: state = SEED, FSM = IDLE, out_valid = 0, lockup = 0, period counter = 0, period_done = 0.
REQ-027 Reset asserted mid-RUN or mid-RECOVER SHALL abort immediately; a pending handshake is discarded.

Configuration
REQ-028 PRNG_LFSR_PERIOD_EN defined: add outputs period_done (1-bit pulse) and period_count (WIDTH bits).
REQ-029 With PRNG_LFSR_PERIOD_EN, the counter SHALL increment per advance and clear on load/recover.
REQ-030 With PRNG_LFSR_PERIOD_EN, when an advance returns the state to the last loaded or reset value: period_done = 1 for one cycle, period_count = steps taken, counter cleared.
REQ-031 PRNG_LFSR_PERIOD_EN undefined: those ports and the counter are absent; all other behaviour is identical.

Structure
REQ-032 Package prng_pkg SHALL hold the MODE_GALOIS/MODE_FIBONACCI constants and the FSM state enum.
REQ-033 The combinational next-state function SHALL live in sub-module lfsr_step (WIDTH, TAPS, MODE); prng_lfsr holds the FSM and registers.

Verification
REQ-034 Default parameters, reset, en = 1, out_ready = 1: out_data 6'b101101 -> 6'b111101 on the first advance.
REQ-035 out_ready held 0 for 5 cycles in RUN: out_data constant, out_valid = 1 throughout.
REQ-036 load with seed_in = 6'b000001: next-cycle out_data = 6'b000001; same-cycle out_ready = 1 does not advance.
REQ-037 load with seed_in = 0: one cycle out_valid = 0, then out_data = 6'b101101 and a single lockup pulse.
REQ-038 WIDTH = 4, TAPS = 4'b0010, Galois, PRNG_LFSR_PERIOD_EN defined, out_ready = 1: period_done after 15 advances with period_count = 15; all-zero state never seen.
REQ-039 Reset asserted during RECOVER: lockup never pulses; out_data = SEED; FSM = IDLE.
